// File: rtl/uart_tx.sv
// 8N1 UART transmitter with an internal baud counter.
// Serialises one byte per valid/ready handshake onto tx.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  generate
    if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
      $error("uart_tx: illegal CLKS_PER_BIT or STOP_BITS");
    end
  endgenerate

  logic [1:0]    r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_idx;
  logic          r_stop;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_ready;
  logic          r_busy;

  logic          w_accept;
  logic          w_bit_end;
  logic          w_last_stop;
  logic [1:0]    w_next;

  assign w_accept    = tx_valid && r_ready;
  assign w_bit_end   = (r_baud == LAST);
  assign w_last_stop = (STOP_BITS == 1) || r_stop;

  // Next-state decode for the frame sequencer.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_START;
      S_START: if (w_bit_end) w_next = S_DATA;
      S_DATA:  if (w_bit_end && r_idx == 3'd7) w_next = S_STOP;
      S_STOP:  if (w_bit_end && w_last_stop) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, handshake flags and the byte latched at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_shift <= 8'h00;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      r_busy  <= (w_next != S_IDLE);
      if (w_accept) r_shift <= tx_data;
    end
  end

  // Baud counter: held at zero while idle, wraps at every bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud <= '0;
    end else if (r_state == S_IDLE || w_bit_end) begin
      r_baud <= '0;
    end else begin
      r_baud <= r_baud + 1'b1;
    end
  end

  // Data bit index and stop-bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= 3'd0;
      r_stop <= 1'b0;
    end else begin
      if (r_state == S_START) r_idx <= 3'd0;
      else if (r_state == S_DATA && w_bit_end) r_idx <= r_idx + 3'd1;
      if (r_state != S_STOP) r_stop <= 1'b0;
      else if (w_bit_end) r_stop <= ~r_stop;
    end
  end

  // Line driver: one cycle behind the state so tx is glitch-free from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx <= 1'b1;
    end else begin
      unique case (r_state)
        S_START: r_tx <= 1'b0;
        S_DATA:  r_tx <= r_shift[r_idx];
        default: r_tx <= 1'b1;
      endcase
    end
  end

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign tx_busy  = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, loopback,
// back-to-back, async reset, busy-ignore, baud sweep.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic [3:0] v;
  logic [3:0] rdy_o;
  logic [3:0] tx_o;
  logic [3:0] busy_o;

  int n_chk;
  int n_pass;
  int cyc;
  int acc_cyc [4];

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v[0]),
    .tx_ready(rdy_o[0]), .tx(tx_o[0]), .tx_busy(busy_o[0]));
  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v[1]),
    .tx_ready(rdy_o[1]), .tx(tx_o[1]), .tx_busy(busy_o[1]));
  uart_tx #(.CLKS_PER_BIT(2), .STOP_BITS(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v[2]),
    .tx_ready(rdy_o[2]), .tx(tx_o[2]), .tx_busy(busy_o[2]));
  uart_tx #(.CLKS_PER_BIT(868), .STOP_BITS(1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v[3]),
    .tx_ready(rdy_o[3]), .tx(tx_o[3]), .tx_busy(busy_o[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int cpb(input int sel);
    case (sel)
      0: return 4;
      1: return 4;
      2: return 2;
      default: return 868;
    endcase
  endfunction

  function automatic int sbits(input int sel);
    return (sel == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input int sel, input logic [7:0] b,
                      input bit hold, input bit poke,
                      input bit chk_per, input string tag);
    int c, s, nn, n, j, nb;
    logic [11:0] bad;
    logic [7:0] rx;
    logic t, e;
    c = cpb(sel);
    s = sbits(sel);
    nn = (9 + s) * c;
    n = 0;
    while (!rdy_o[sel] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " rdy"}, 32'(rdy_o[sel]), 32'd1);
    tx_data = b;
    v[sel] = 1'b1;
    @(negedge clk);
    if (!hold) v[sel] = 1'b0;
    tx_data = ~b;
    if (chk_per) chk({tag, " period"}, 32'(cyc - acc_cyc[sel]), 32'(nn + 1));
    acc_cyc[sel] = cyc;
    bad = '0;
    rx = '0;
    nb = 0;
    for (int k = 0; k <= nn; k++) begin
      if (k > 0) @(negedge clk);
      if (poke && k == 10) begin
        v[sel] = 1'b1;
        tx_data = 8'h00;
      end
      if (poke && k == 11) v[sel] = 1'b0;
      t = tx_o[sel];
      if (k == 0) begin
        chk({tag, " lat"}, 32'(t), 32'd1);
      end else begin
        j = (k - 1) / c;
        if (j == 0) e = 1'b0;
        else if (j <= 8) e = b[j-1];
        else e = 1'b1;
        if (t !== e) bad[j] = 1'b1;
        if ((k - 1) % c == c / 2 && j >= 1 && j <= 8) rx[j-1] = t;
      end
      if (busy_o[sel]) nb++;
    end
    for (int i = 0; i < 9 + s; i++)
      chk($sformatf("%s bit%0d", tag, i), 32'(bad[i]), 32'd0);
    chk({tag, " rx"}, 32'(rx), 32'(b));
    chk({tag, " busy"}, 32'(nb), 32'(nn));
    chk({tag, " ready"}, 32'(rdy_o[sel]), 32'd1);
  endtask

  initial begin
    logic bt, br, bb;
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    v = '0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    bt = 0; br = 0; bb = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_o !== 4'hF) bt = 1;
      if (rdy_o !== 4'hF) br = 1;
      if (busy_o !== 4'h0) bb = 1;
    end
    chk("idle tx", 32'(bt), 32'd0);
    chk("idle ready", 32'(br), 32'd0);
    chk("idle busy", 32'(bb), 32'd0);

    send(0, 8'h55, 0, 0, 0, "f55");
    send(0, 8'hA3, 0, 0, 0, "fA3");

    send(1, 8'h00, 1, 0, 0, "s2 f00");
    send(1, 8'hFF, 1, 0, 1, "s2 fFF");
    v[1] = 1'b0;

    tx_data = 8'h0F;
    v[0] = 1'b1;
    @(negedge clk);
    v[0] = 1'b0;
    repeat (18) @(negedge clk);
    chk("rst pre busy", 32'(busy_o[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst tx", 32'(tx_o[0]), 32'd1);
    chk("rst ready", 32'(rdy_o[0]), 32'd1);
    chk("rst busy", 32'(busy_o[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h81, 0, 0, 0, "f81");

    send(0, 8'h3C, 0, 1, 0, "poke");
    bt = 0;
    repeat (45) begin
      @(negedge clk);
      if (tx_o[0] !== 1'b1 || rdy_o[0] !== 1'b1) bt = 1;
    end
    chk("no extra frame", 32'(bt), 32'd0);

    send(2, 8'hA5, 0, 0, 0, "c2 fA5");
    send(2, 8'h5A, 0, 0, 1, "c2 f5A");
    send(3, 8'h3C, 0, 0, 0, "c868 f3C");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
